// File: rtl/ssd_pkg.sv
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and constants for the seven-segment scan
//               controller: FSM encoding, hex segment table, blank pattern.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ssd_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    localparam logic [7:0] CATHODES_OFF = 8'hFF;

    // Segment order abcdefg, active-low.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_hex_decoder.sv
// ============================================================================
// Module      : ssd_hex_decoder
// Description : Combinational hex nibble + decimal point to active-low
//               cathode pattern {Ca..Cg, Dp}.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] cathodes_o
);

    assign cathodes_o = {hex_seg(nibble_i), ~dp_i};

endmodule

`default_nettype wire

// File: rtl/ssd_scan_controller.sv
// ============================================================================
// Module      : ssd_scan_controller
// Description : Time-multiplexed seven-segment scanner with shadowed value,
//               frame-aligned load/ack commit and inter-digit blanking.
//               Optional build macro SSD_LEADING_ZERO_BLANK_EN suppresses
//               leading zero digits (digit 0 always shown).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 18,
    parameter int BLANK_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cathodes,
    output logic                    frame_done
);

    localparam int                 DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SCAN_DIV-1:0] CNT_MAX    = {SCAN_DIV{1'b1}};
    localparam logic [SCAN_DIV-1:0] CNT_PRE    = CNT_MAX - SCAN_DIV'(1);
    localparam logic [SCAN_DIV-1:0] BLANK_LAST = SCAN_DIV'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [DIG_W-1:0]    LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam bit                  HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam scan_state_e         RESET_STATE = HAS_BLANK ? ST_BLANK : ST_SHOW;

    logic [SCAN_DIV-1:0]     cnt_q;
    logic [DIG_W-1:0]        digit_q;
    logic [DIG_W-1:0]        digit_d;
    scan_state_e             state_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [7:0]              cath_q;
    logic                    frame_done_q;
    logic                    load_ack_q;

    logic [4*NUM_DIGITS-1:0] shadow_val_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic [4*NUM_DIGITS-1:0] pend_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic                    pending_q;

    logic                    w_wrap;
    logic                    w_boundary;
    logic                    w_pre_boundary;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [3:0]              w_cur_nib;
    logic                    w_cur_dp;
    logic [7:0]              w_dec_cath;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_visible;
    logic [NUM_DIGITS-1:0]   w_an_show;

    assign w_wrap         = (cnt_q == CNT_MAX);
    assign w_boundary     = w_wrap && (digit_q == LAST_DIGIT);
    // Registered pulses are launched one cycle early so they coincide with the boundary cycle.
    assign w_pre_boundary = (cnt_q == CNT_PRE) && (digit_q == LAST_DIGIT);

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
            assign w_nib[k] = shadow_val_q[4*k +: 4];
        end
    endgenerate

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // w_zero_from[k]: digits k..top all have zero nibble and unlit dp.
    logic [NUM_DIGITS:0] w_zero_from;
    assign w_zero_from[NUM_DIGITS] = 1'b1;

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
            assign w_zero_from[k] = w_zero_from[k+1] && (w_nib[k] == 4'h0) && !shadow_dp_q[k];
            if (k == 0) begin : g_lsd
                assign w_lz_blank[k] = 1'b0;
            end else begin : g_upper
                assign w_lz_blank[k] = w_zero_from[k];
            end
        end
    endgenerate
`else
    assign w_lz_blank = '0;
`endif

    assign w_cur_nib = w_nib[digit_q];
    assign w_cur_dp  = shadow_dp_q[digit_q];
    assign w_visible = digit_en[digit_q] && !w_lz_blank[digit_q];
    assign w_an_show = ~(NUM_DIGITS'(1) << digit_q);

    ssd_hex_decoder u_hex_decoder (
        .nibble_i   (w_cur_nib),
        .dp_i       (w_cur_dp),
        .cathodes_o (w_dec_cath)
    );

    always_comb begin
        digit_d = digit_q;
        if (w_wrap) begin
            digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q        <= '0;
            digit_q      <= '0;
            state_q      <= RESET_STATE;
            an_q         <= '1;
            cath_q       <= CATHODES_OFF;
            frame_done_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + SCAN_DIV'(1);
            digit_q <= digit_d;

            case (state_q)
                ST_BLANK: if (cnt_q == BLANK_LAST) state_q <= ST_SHOW;
                ST_SHOW:  if (w_wrap && HAS_BLANK) state_q <= ST_BLANK;
            endcase

            // Disabled digits still consume their slot, keeping brightness uniform.
            if ((state_q == ST_SHOW) && w_visible) begin
                an_q   <= w_an_show;
                cath_q <= w_dec_cath;
            end else begin
                an_q   <= '1;
                cath_q <= CATHODES_OFF;
            end

            frame_done_q <= w_pre_boundary;
            load_ack_q   <= w_pre_boundary && (pending_q || load);
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (w_boundary && pending_q) begin
                shadow_val_q <= pend_val_q;
                shadow_dp_q  <= pend_dp_q;
                pending_q    <= 1'b0;
            end
            // A load in the boundary cycle becomes pending for the next frame.
            if (load) begin
                pend_val_q <= value_in;
                pend_dp_q  <= dp_in;
                pending_q  <= 1'b1;
            end
        end
    end

    assign An         = an_q;
    assign Cathodes   = cath_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
// ============================================================================
// Module      : tb_ssd_scan_controller
// Description : Self-checking bench for ssd_scan_controller; honours the
//               SSD_LEADING_ZERO_BLANK_EN build macro in its reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ssd_scan_controller;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = 1 << SD;
    localparam int FRAME = SLOT * ND;

    logic          clk = 1'b0;
    logic          Reset_n;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          load;
    logic          load_ack;
    logic [3:0]    An;
    logic [7:0]    Cathodes;
    logic          frame_done;

    always #5 clk = ~clk;

    ssd_scan_controller #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .load_ack   (load_ack),
        .An         (An),
        .Cathodes   (Cathodes),
        .frame_done (frame_done)
    );

    int vectors = 0;
    int errs    = 0;
    int ack_seen = 0;

    // Reference model: absolute cycle index since reset release, plus committed/pending values.
    int          m_c;
    logic [15:0] sh_v, pv;
    logic [3:0]  sh_dp, pdp;
    bit          m_pend;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  exp_an;
        logic [7:0]  exp_cath;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic bit ref_lz(input int d);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        return (d > 0) && ((sh_v >> (4*d)) == 16'h0) && ((sh_dp >> d) == 4'h0);
`else
        return (d < 0);
`endif
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (model cycle %0d)", nm, act, exp, m_c);
        end
    endfunction

    task automatic tick();
        logic [15:0] v_s;
        logic [3:0]  dp_s, en_s, exp_an;
        logic [7:0]  exp_cath;
        logic        ld_s;
        bit          chk_cath;
        int          cnt, dig;
        v_s = value_in; dp_s = dp_in; en_s = digit_en; ld_s = load;
        @(posedge clk);
        #1;
        cnt = m_c % SLOT;
        dig = (m_c / SLOT) % ND;
        exp_an = 4'hF; exp_cath = 8'hFF; chk_cath = 1'b1;
        if (cnt >= BC) begin
            if (en_s[dig] && !ref_lz(dig)) begin
                exp_an   = ~(4'b0001 << dig);
                exp_cath = {ref_seg(sh_v[dig*4 +: 4]), ~sh_dp[dig]};
            end else begin
                chk_cath = 1'b0;
            end
        end
        if ((m_c % FRAME) == FRAME - 1 && m_pend) begin
            sh_v = pv; sh_dp = pdp; m_pend = 1'b0;
        end
        if (ld_s) begin
            pv = v_s; pdp = dp_s; m_pend = 1'b1;
        end
        m_c++;
        check("An", 32'(An), 32'(exp_an));
        if (chk_cath) check("Cathodes", 32'(Cathodes), 32'(exp_cath));
        check("frame_done", 32'(frame_done), 32'((m_c % FRAME) == FRAME - 1));
        check("load_ack", 32'(load_ack), 32'(((m_c % FRAME) == FRAME - 1) && m_pend));
        if (load_ack) ack_seen++;
    endtask

    task automatic to_pos(input int p);
        for (int i = 0; i < FRAME && (m_c % FRAME) != p; i++) tick();
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (!load_ack && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, a0, lit;
        tbl[0] = '{16'h1234, 4'b0000, 4'b1111, 4'b1110, 8'h99};
        tbl[1] = '{16'hAAAA, 4'b0001, 4'b1111, 4'b1110, 8'h10};
        tbl[2] = '{16'h5555, 4'b0000, 4'b1111, 4'b1110, 8'h49};
        tbl[3] = '{16'hBEEF, 4'b0000, 4'b0101, 4'b1110, 8'h71};
        tbl[4] = '{16'h0008, 4'b0001, 4'b1111, 4'b1110, 8'h00};
        tbl[5] = '{16'hC0DE, 4'b0000, 4'b1111, 4'b1110, 8'h61};

        Reset_n = 1'b0; value_in = '0; dp_in = '0; digit_en = 4'hF; load = 1'b0;
        m_c = 0; sh_v = '0; sh_dp = '0; pv = '0; pdp = '0; m_pend = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_An", 32'(An), 32'hF);
        check("rst_Cathodes", 32'(Cathodes), 32'hFF);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_load_ack", 32'(load_ack), 32'h0);
        @(negedge clk);
        Reset_n = 1'b1;

        repeat (3) tick();
        check("first_show_An", 32'(An), 32'hE);
        check("first_show_Cathodes", 32'(Cathodes), 32'h03);

        for (int i = 0; i < 6; i++) begin
            value_in = tbl[i].val; dp_in = tbl[i].dp; digit_en = tbl[i].en;
            load = 1'b1;
            tick();
            load = 1'b0;
            wait_ack(n);
            check("tbl_ack_timeout", 32'(n < 200), 32'h1);
            repeat (4) tick();
            check("tbl_An", 32'(An), 32'(tbl[i].exp_an));
            check("tbl_Cathodes", 32'(Cathodes), 32'(tbl[i].exp_cath));
        end

        // Load landing in the boundary cycle while a value is still pending.
        digit_en = 4'hF;
        to_pos(10);
        value_in = 16'h00FF; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        to_pos(FRAME - 1);
        check("boundary_first_ack", 32'(load_ack), 32'h1);
        value_in = 16'h9876; load = 1'b1;
        tick();
        load = 1'b0;
        n = 1;
        while (!load_ack && n < 100) begin
            tick();
            n++;
        end
        check("boundary_ack_interval", 32'(n), 32'(FRAME));

        // Two loads in one frame give a single ack and the later value.
        to_pos(5);
        value_in = 16'hAAAA; load = 1'b1; tick(); load = 1'b0;
        to_pos(20);
        value_in = 16'h5555; load = 1'b1; tick(); load = 1'b0;
        a0 = ack_seen;
        repeat (130) tick();
        check("double_load_acks", 32'(ack_seen - a0), 32'h1);
        to_pos(3);
        check("double_load_An", 32'(An), 32'hE);
        check("double_load_Cathodes", 32'(Cathodes), 32'h49);

        // Disabled digits keep their slot dark while the frame period is unchanged.
        digit_en = 4'b0101; value_in = 16'h1234; load = 1'b1; tick(); load = 1'b0;
        wait_ack(n);
        lit = 0;
        repeat (FRAME) begin
            tick();
            if (An != 4'hF) lit++;
        end
        check("digit_en_lit_cycles", 32'(lit), 32'(2 * (SLOT - BC)));

        for (int i = 0; i < 1200; i++) begin
            load = ($urandom_range(0, 39) == 0);
            if (load) begin
                value_in = 16'($urandom);
                dp_in    = 4'($urandom);
            end
            if ($urandom_range(0, 99) == 0) digit_en = 4'($urandom);
            tick();
        end
        load = 1'b0;

        // Mid-frame reset with data pending.
        digit_en = 4'hF;
        to_pos(30);
        value_in = 16'h4321; load = 1'b1; tick(); load = 1'b0;
        repeat (2) tick();
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_An", 32'(An), 32'hF);
        check("midrst_Cathodes", 32'(Cathodes), 32'hFF);
        check("midrst_load_ack", 32'(load_ack), 32'h0);
        m_c = 0; sh_v = '0; sh_dp = '0; m_pend = 1'b0;
        @(negedge clk);
        Reset_n = 1'b1;
        a0 = ack_seen;
        repeat (140) tick();
        check("midrst_no_ack", 32'(ack_seen - a0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Time-multiplexes the Nexys seven-segment display across NUM_DIGITS digits, replacing ad-hoc anode scanning in the top level.
- Holds a shadow copy of the displayed value and accepts new values through a load/ack handshake.
- Commits a new value only at frame boundaries, so the score never tears mid-scan.
- Inserts a blanking interval between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (1..8).
- SCAN_DIV, 18, each digit slot lasts 2^SCAN_DIV clk cycles.
- BLANK_CYCLES, 256, cycles at the start of each slot with all anodes off. Must be < 2^SCAN_DIV; 0 disables blanking.

Ports:
- clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- value_in  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit k is displayed; sampled live.
- load  in  1  one-cycle request to capture value_in/dp_in.
- load_ack  out  1  one-cycle pulse when a captured value becomes visible.
- An  out  NUM_DIGITS  anodes, active-low.
- Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot.

Behaviour:
- Reset (async assert, sync release):
  - An = all 1, Cathodes = 8'hFF.
  - load_ack = 0, frame_done = 0.
  - shadow value/dp = 0, pending flag = 0.
  - digit index = 0, slot counter = 0, state = BLANK (SHOW if BLANK_CYCLES = 0).
- Slot counter is SCAN_DIV bits wide, increments every cycle and wraps at 2^SCAN_DIV - 1.
- FSM:
  - BLANK: entered when the counter wraps to 0. Moves to SHOW when counter == BLANK_CYCLES-1.
  - SHOW: moves to BLANK when counter == 2^SCAN_DIV-1, and the digit index advances.
  - Digit index wraps from NUM_DIGITS-1 to 0.
- Outputs are registered and reflect the current state one cycle after the state register.
  - BLANK: An all 1, Cathodes 8'hFF.
  - SHOW with digit_en[k] = 1: An[k] = 0 (others 1); Cathodes = {hex_seg(shadow nibble k), ~shadow_dp[k]}.
  - SHOW with digit_en[k] = 0: An all 1 for the slot; slot time is still consumed so brightness stays uniform.
- Hex segment encoding (abcdefg, active-low):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, B:1100000, C:0110001, D:1000010, E:0110000, F:0111000
- Load handshake:
  - A load pulse copies value_in/dp_in into a pending register and sets the pending flag.
  - A second load while pending overwrites the pending register. Only the final value is acked.
- Frame boundary:
  - The boundary is the cycle where digit index = NUM_DIGITS-1 and the counter wraps. frame_done pulses in that cycle.
  - If pending is set: pending copies to shadow, pending clears, load_ack pulses in the same cycle, and the new value is visible from digit 0 of the next frame.
  - Load coinciding with a boundary when pending is set: the old pending commits and is acked; the new value becomes pending for the next boundary.
  - Load coinciding with a boundary when pending is clear: the value is captured as pending and committed at the following boundary.
- A mid-frame Reset_n assertion blanks outputs immediately (asynchronous) and discards pending data.

Optional Feature:
- SSD_LEADING_ZERO_BLANK_EN, when defined:
  - An enabled digit k > 0 is blanked (An[k] = 1) if its shadow nibble and all higher shadow nibbles are 0 and their dp bits are 0.
  - Digit 0 is never suppressed.
  - Example: 16'h0042 lights only digits 1 and 0.
- When undefined: all enabled digits display, including leading zeros.

Decomposition:
- Package ssd_pkg contains:
  - FSM state encoding (BLANK, SHOW).
  - The 16-entry hex-to-segment constant table.
  - Constant CATHODES_OFF = 8'hFF.
- One combinational sub-module, ssd_hex_decoder: 4-bit nibble + dp in, 8-bit Cathodes out.
- Counter, FSM, shadow/pending registers and anode generation stay in ssd_scan_controller.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=2, NUM_DIGITS=4):
- Reset_n low, then release. An = 4'b1111 and Cathodes = 8'hFF during reset. After release, the first SHOW of digit 0 displays 0: An = 4'b1110, Cathodes = 8'b00000011 on cycle 3.
- load value_in = 16'h1234, dp_in = 0. load_ack pulses exactly at the next frame_done. The next frame shows An = 1110/1101/1011/0111 with Cathodes = "4"/"3"/"2"/"1", each lasting 14 cycles separated by 2 blank cycles.
- Two loads (16'hAAAA, then 16'h5555) in the same frame produce a single load_ack, and only 5555 is displayed.
- digit_en = 4'b0101 with value 16'h1234: slots 1 and 3 keep An = 1111 for the full 16 cycles; the frame period remains 64 cycles.
- Load asserted in the frame_done cycle while 16'h00FF is pending: 00FF is acked now and the new value is acked one frame (64 cycles) later.
- With SSD_LEADING_ZERO_BLANK_EN defined, value 16'h0042 lights digits 0 and 1 only; value 16'h0000 lights digit 0 only, showing "0".
